muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer and HI/LO register owner for the pipelined MIPS execute stage. It decodes the SPECIAL multiply/divide and HI/LO-move instructions, runs a 32-iteration shift-add multiply or restoring divide on one shared 33-bit adder, and asserts a pipeline stall while a HI/LO-dependent instruction waits for an operation still in flight. It sits beside the main ALU in EX; the main ALU treats these funct codes as undefined.

## Interface
- No parameters; operand width fixed at 32.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: valid instruction present in EX this cycle.
- `opcode` in 6: instruction opcode.
- `funct` in 6: instruction funct field.
- `rs_val` in 32: forwarded rs operand (dividend / multiplicand / MTHI/MTLO source).
- `rt_val` in 32: forwarded rt operand (divisor / multiplier).
- `stall` out 1: hold IF/ID/EX and bubble MEM. Combinational.
- `busy` out 1: operation in flight. Registered.
- `hilo_out` out 32: HI for MFHI, LO for MFLO, else 0. Combinational.
- `hi`, `lo` out 32 each: architectural HI/LO registers.

## Operation
- Recognised only when `opcode`==SPECIAL: MULT, MULTU, DIV, DIVU (start ops); MFHI, MFLO (reads); MTHI, MTLO (writes). `hilo_op` = any of the eight.
- `stall` = `en` & `hilo_op` & `busy`. A stalled instruction stays in EX with `en` high and is accepted the first cycle `busy` is low.
- FSM states: IDLE, RUN, FIX.
  - IDLE: accepted start op latches |rs|, |rt| (absolute value for signed ops, raw for unsigned), result-sign flags, op kind; clears iteration counter; -> RUN. MTHI/MTLO write `rs_val` into HI/LO at the clock edge. MFHI/MFLO drive `hilo_out` from current HI/LO.
  - RUN: 32 iterations, one per cycle, counter 0..31. Multiply: LSB-first shift-add into a 64-bit accumulator. Divide: restoring, MSB-first; 33-bit trial subtract; quotient bit = no borrow. After iteration 31 -> FIX.
  - FIX: apply sign. Multiply: negate 64-bit product if operand signs differ. Divide: negate quotient if signs differ; remainder takes the dividend's sign. Write HI (upper / remainder) and LO (lower / quotient). -> IDLE.
- Divide by zero (`rt_val`==0): no trap. Iterations still run; LO=0xFFFFFFFF, HI=`rs_val` for both DIV and DIVU, with the signed fixup suppressed.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural result of the absolute-value path.
- Non-hilo instructions are ignored in every state and never stall.
- `rst` in any state: -> IDLE; counter, accumulator, HI, LO cleared. An in-flight result is discarded.

## Timing
- Reset values: `busy`=0, `stall`=0, `hilo_out`=0, `hi`=0, `lo`=0.
- Start op accepted in cycle t.
  - `busy` is high t+1..t+33 (RUN t+1..t+32, FIX t+33).
  - HI/LO hold their new values from t+34.
  - `busy`=0 at t+34.
- An MFHI/MFLO in EX at t+1 stalls 33 cycles and reads the new value at t+34.
- Back-to-back: a start op in EX at t+1 stalls until t+34, then starts. The old result is already committed at that point.
- MTHI/MTLO in IDLE: visible on `hi`/`lo` next cycle. An MFHI in the cycle immediately after sees the written value.
- HI/LO change only in FIX, on MTHI/MTLO, or on reset.

## Structure
- Funct codes belong in the shared `mips.h`: SPECIAL, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13.
- FSM state encodings are local `define`s guarded like other headers.
- One sub-module, `muldiv_iter`: the accumulator/remainder registers, shared 33-bit adder/subtractor, and per-step shift logic.
  - `muldiv_ctrl` keeps the decode, FSM, counter, sign fixup, HI/LO, and stall logic.

## Test plan
- MULT rs=0xFFFFFFFF, rt=2 -> at t+34, HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1.
- DIV rs=0x12345678, rt=0 -> LO=0xFFFFFFFF, HI=0x12345678. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT issued at t, then MFLO held in EX from t+1 -> `stall` high exactly t+1..t+33, `hilo_out` correct at t+34. An ADDU in EX during `busy` -> no stall.
- MTLO rs=0xDEADBEEF in IDLE, then MFLO next cycle -> `hilo_out`=0xDEADBEEF, no stall.
- `rst` asserted at t+10 of a MULT -> the next cycle shows `busy`=0, HI=LO=0, and a new MULT issued right after produces the correct product at its own t+34.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared opcode/funct encodings and FSM state type for the multiply/divide unit.
package muldiv_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    localparam logic [4:0] LAST_ITER = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for the iterative multiply/divide: 64-bit accumulator, operand
// register and the single shared 33-bit adder/subtractor.
// Multiply: acc = {partial, multiplier}; each step adds the multiplicand when
// acc[0] is set and shifts right one place.
// Divide:   acc = {remainder, dividend}; each step shifts left one place,
// trial-subtracts the divisor and shifts in the quotient bit (1 = no borrow).
module muldiv_iter
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [63:0] acc
);

    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic [32:0] add_x, add_y;
    logic        add_cin;
    logic [33:0] add_sum;

    // Shared adder: add for multiply, subtract (x + ~y + 1) for divide
    always_comb begin
        add_x   = {1'b0, acc_q[63:32]};
        add_y   = '0;
        add_cin = 1'b0;
        if (is_div) begin
            add_x   = acc_q[63:31];
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else if (acc_q[0]) begin
            add_y = {1'b0, opnd_q};
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {33'b0, add_cin};
    end

    // Next accumulator/operand: load operands or apply one iteration
    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        if (load) begin
            acc_d  = {32'b0, (is_div ? a_in : b_in)};
            opnd_d = is_div ? b_in : a_in;
        end else if (step) begin
            if (is_div) begin
                // add_sum[33] is the carry out: set when no borrow
                acc_d = {(add_sum[33] ? add_sum[31:0] : acc_q[62:31]),
                         acc_q[30:0], add_sum[33]};
            end else begin
                acc_d = {add_sum[32:0], acc_q[31:1]};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer and HI/LO owner for the EX stage. Decodes the
// SPECIAL mul/div and HI/LO moves, runs 32 iterations in muldiv_iter, applies
// the sign fixup and stalls HI/LO-dependent instructions while busy.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        busy,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        kind_div_q, kind_div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic        is_special, start_op, hilo_op, accept;
    logic        op_signed, op_div, div_zero, rs_neg, rt_neg;
    logic [31:0] rs_abs, rt_abs;
    logic        iter_load, iter_step, iter_is_div;
    logic [63:0] acc, prod_neg;

    // Instruction decode and operand conditioning
    always_comb begin
        is_special = (opcode == OP_SPECIAL);
        start_op   = is_special && (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
        hilo_op    = start_op || (is_special &&
                     (funct inside {FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO}));
        accept     = en && hilo_op && !busy_q;
        op_signed  = (funct == FN_MULT) || (funct == FN_DIV);
        op_div     = (funct == FN_DIV) || (funct == FN_DIVU);
        div_zero   = op_div && (rt_val == 32'd0);
        rs_neg     = op_signed && rs_val[31];
        rt_neg     = op_signed && rt_val[31];
        // Divide by zero keeps the raw dividend so HI ends up equal to rs_val
        rs_abs     = (rs_neg && !div_zero) ? (32'd0 - rs_val) : rs_val;
        rt_abs     = rt_neg ? (32'd0 - rt_val) : rt_val;
    end

    // FSM next state, counter, sign flags and HI/LO updates
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        kind_div_d = kind_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        iter_load  = 1'b0;
        iter_step  = 1'b0;
        prod_neg   = 64'd0 - acc;
        case (state_q)
            ST_IDLE: begin
                if (accept && start_op) begin
                    iter_load  = 1'b1;
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    kind_div_d = op_div;
                    neg_lo_d   = !div_zero && (rs_neg ^ rt_neg);
                    neg_hi_d   = !div_zero && (op_div ? rs_neg : (rs_neg ^ rt_neg));
                end else if (accept && funct == FN_MTHI) begin
                    hi_d = rs_val;
                end else if (accept && funct == FN_MTLO) begin
                    lo_d = rs_val;
                end
            end
            ST_RUN: begin
                iter_step = 1'b1;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (kind_div_q) begin
                    lo_d = neg_lo_q ? (32'd0 - acc[31:0])  : acc[31:0];
                    hi_d = neg_hi_q ? (32'd0 - acc[63:32]) : acc[63:32];
                end else begin
                    lo_d = neg_lo_q ? prod_neg[31:0]  : acc[31:0];
                    hi_d = neg_lo_q ? prod_neg[63:32] : acc[63:32];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d      = (state_d != ST_IDLE);
        iter_is_div = (state_q == ST_IDLE) ? op_div : kind_div_q;
    end

    // Control and architectural registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            kind_div_q <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            busy_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            kind_div_q <= kind_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            busy_q     <= busy_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    muldiv_iter u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (iter_load),
        .step   (iter_step),
        .is_div (iter_is_div),
        .a_in   (rs_abs),
        .b_in   (rt_abs),
        .acc    (acc)
    );

    // Stall and HI/LO read port
    always_comb begin
        stall    = en && hilo_op && busy_q;
        hilo_out = '0;
        if (en && is_special && funct == FN_MFHI) begin
            hilo_out = hi_q;
        end else if (en && is_special && funct == FN_MFLO) begin
            hilo_out = lo_q;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: arithmetic reference model checked every cycle,
// directed corner cases with literal expectations, then random instructions.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic [5:0]  funct = 6'h00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        stall, busy;
    logic [31:0] hilo_out, hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int          m_cnt = 0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .opcode(opcode), .funct(funct),
        .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .busy(busy),
        .hilo_out(hilo_out), .hi(hi), .lo(lo)
    );

    // clock / global time guard
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    function automatic bit is_hilo(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'h00) && (fn inside {6'h10, 6'h11, 6'h12, 6'h13,
                                            6'h18, 6'h19, 6'h1A, 6'h1B});
    endfunction

    // result of a start op, from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [5:0] fn,
                                               input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] u;
        case (fn)
            6'h18: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                u  = 64'(sa * sb);
            end
            6'h19: u = {32'b0, a} * {32'b0, b};
            6'h1A: begin
                if (b == 0) u = {a, 32'hFFFFFFFF};
                else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    sq = sa / sb;
                    sr = sa % sb;
                    u  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 0) u = {a, 32'hFFFFFFFF};
                else        u = {a % b, a / b};
            end
        endcase
        return u;
    endfunction

    // model: busy lasts 33 cycles after a start, then HI/LO commit
    always @(posedge clk) begin
        logic [63:0] r;
        if (rst) begin
            m_cnt = 0; m_hi = '0; m_lo = '0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (en && is_hilo(opcode, funct)) begin
            case (funct)
                6'h11: m_hi = rs_val;
                6'h13: m_lo = rs_val;
                6'h18, 6'h19, 6'h1A, 6'h1B: begin
                    r     = ref_result(funct, rs_val, rt_val);
                    p_hi  = r[63:32];
                    p_lo  = r[31:0];
                    m_cnt = 33;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: all outputs against the model every cycle
    always @(negedge clk) begin
        logic [31:0] e_ho;
        if (chk_on) begin
            e_ho = '0;
            if (en && opcode == 6'h00 && funct == 6'h10) e_ho = m_hi;
            if (en && opcode == 6'h00 && funct == 6'h12) e_ho = m_lo;
            check("stall", stall, en && is_hilo(opcode, funct) && (m_cnt > 0));
            check("busy", busy, m_cnt > 0);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
            check("hilo_out", hilo_out, e_ho);
        end
    end

    // driver: present an instruction, hold it while stalled, return stall count
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic [31:0] a, input logic [31:0] b,
                             output int stalls, output logic [31:0] ho);
        en = 1'b1; opcode = op; funct = fn; rs_val = a; rt_val = b;
        #1;
        stalls = 0;
        while (stall && stalls < 100) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (stall) begin
            n_checks++; n_fail++;
            $display("FAIL stall_timeout: got stalled expected released");
        end
        ho = hilo_out;
        @(negedge clk); #1;
        en = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 100) begin
            @(negedge clk); #1;
            cycles++;
        end
        if (busy) begin
            n_checks++; n_fail++;
            $display("FAIL busy_timeout: got busy expected idle");
        end
    endtask

    task automatic do_op(input string name, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
        int          s, c;
        logic [31:0] ho;
        run_instr(6'h00, fn, a, b, s, ho);
        wait_idle(c);
        check({name, "_cycles"}, c, 33);
        check({name, "_hi"}, hi, e_hi);
        check({name, "_lo"}, lo, e_lo);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          s, c, sel;
        logic [31:0] ho;
        logic [5:0]  fn, op;

        // reset
        repeat (2) @(negedge clk);
        #1;
        chk_on = 1'b1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_hilo_out", hilo_out, 0);

        // directed arithmetic cases
        do_op("mult_neg1x2",  6'h18, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("multu_ffx2",   6'h19, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        do_op("div_m7_2",     6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("divu_7_2",     6'h1B, 32'd7,        32'd2, 32'd1,        32'd3);
        do_op("div_by_zero",  6'h1A, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        do_op("div_neg_by_0", 6'h1A, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        do_op("divu_by_zero", 6'h1B, 32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF);
        do_op("div_min_neg1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // MFLO held in EX right behind a MULT
        run_instr(6'h00, 6'h18, 32'd3, 32'd5, s, ho);
        run_instr(6'h00, 6'h12, 32'd0, 32'd0, s, ho);
        check("mflo_stall_cycles", s, 33);
        check("mflo_after_mult", ho, 32'd15);

        // ADDU during busy does not stall
        run_instr(6'h00, 6'h18, 32'd6, 32'd7, s, ho);
        run_instr(6'h00, 6'h21, 32'd1, 32'd1, s, ho);
        check("addu_no_stall", s, 0);
        check("addu_busy", busy, 1);
        // back-to-back start waits, then runs
        run_instr(6'h00, 6'h1B, 32'd100, 32'd7, s, ho);
        check("b2b_stall_cycles", s, 32);
        check("b2b_old_lo", lo, 32'd42);
        wait_idle(c);
        check("b2b_hi", hi, 32'd2);
        check("b2b_lo", lo, 32'd14);

        // MTLO then MFLO next cycle
        run_instr(6'h00, 6'h13, 32'hDEADBEEF, 32'd0, s, ho);
        run_instr(6'h00, 6'h12, 32'd0, 32'd0, s, ho);
        check("mtlo_mflo_stall", s, 0);
        check("mtlo_mflo_val", ho, 32'hDEADBEEF);
        run_instr(6'h00, 6'h11, 32'hCAFEF00D, 32'd0, s, ho);
        run_instr(6'h00, 6'h10, 32'd0, 32'd0, s, ho);
        check("mthi_mfhi_val", ho, 32'hCAFEF00D);

        // reset in the middle of a MULT
        run_instr(6'h00, 6'h18, 32'hFFFFFFFF, 32'd2, s, ho);
        repeat (9) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        do_op("after_rst_mult", 6'h18, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);

        // random instruction stream
        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 11);
            op  = ($urandom_range(0, 9) == 0) ? 6'h08 : 6'h00;
            case (sel)
                0, 1: fn = 6'h18;
                2:    fn = 6'h19;
                3, 4: fn = 6'h1A;
                5:    fn = 6'h1B;
                6:    fn = 6'h10;
                7:    fn = 6'h12;
                8:    fn = 6'h11;
                9:    fn = 6'h13;
                10:   fn = 6'h21;
                default: fn = 6'h20;
            endcase
            run_instr(op, fn, rand_opnd(), rand_opnd(), s, ho);
            repeat ($urandom_range(0, 3)) begin @(negedge clk); #1; end
        end
        wait_idle(c);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
